// File: rtl/edge_det_pkg.sv
// ---------------------------------------------------------------------------
// edge_det_pkg
// Shared definitions for the multi-channel edge detector:
//   - per-channel mode encodings (bit 0 enables rising, bit 1 enables falling)
//   - clog2 constant function used to size the debounce counters
// ---------------------------------------------------------------------------
package edge_det_pkg;

    localparam logic [1:0] EDGE_OFF  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    // Ceiling log2; clog2(0) = clog2(1) = 0.
    function automatic int clog2(input int unsigned value);
        int          result;
        int unsigned rem;
        result = 0;
        if (value > 1) begin
            rem = value - 1;
            while (rem > 0) begin
                result = result + 1;
                rem    = rem >> 1;
            end
        end
        return result;
    endfunction

endpackage : edge_det_pkg

// File: rtl/edge_det_chan.sv
// ---------------------------------------------------------------------------
// edge_det_chan
// One detector channel: optional synchroniser chain, stable-count debounce,
// level / delayed-level flops, rise/fall pulses, mode-masked event pulse and
// (with EDGE_DET_STICKY_EN defined) a sticky event flag.
//
// Configuration macro: EDGE_DET_STICKY_EN
//   defined   -> flag sets on evt, clears on clr, set wins on a tie
//   undefined -> clr ignored, flag tied to 0, no flag flop
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   data   in   raw channel input (may be asynchronous)
//   mode   in   [0] report rising edges, [1] report falling edges
//   clr    in   sticky-flag clear
//   level  out  synchronised, debounced level
//   pos    out  one-cycle pulse on level 0->1
//   neg    out  one-cycle pulse on level 1->0
//   evt    out  pos/neg masked by mode
//   flag   out  sticky event flag
// ---------------------------------------------------------------------------
module edge_det_chan
    import edge_det_pkg::*;
#(
    parameter int SYNC_STG = 2,
    parameter int DB_CYC   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       level,
    output logic       pos,
    output logic       neg,
    output logic       evt,
    output logic       flag
);

    // DB_CYC of 0 and 1 both mean "accept a change after one stable sample".
    localparam int DB_EFF    = (DB_CYC < 1) ? 1 : DB_CYC;
    localparam int CNT_W_RAW = clog2(DB_CYC + 1);
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_EFF - 1);

    logic             synced;
    logic [CNT_W-1:0] cnt;
    logic             level_q;
    logic             level_d1;

    generate
        if (SYNC_STG == 0) begin : g_nosync
            assign synced = data;
        end else begin : g_sync
            logic [SYNC_STG-1:0] sync_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= data;
                    for (int k = 1; k < SYNC_STG; k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end

            assign synced = sync_q[SYNC_STG-1];
        end
    endgenerate

    // The counter only runs while synced disagrees with level, and is cleared
    // both on acceptance and on any return to agreement, so it can never wrap
    // and a short excursion leaves no residue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            level_q <= 1'b0;
        end else if (synced == level_q) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level_q <= synced;
            cnt     <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d1 <= 1'b0;
        end else begin
            level_d1 <= level_q;
        end
    end

    // Pulses decode two flops only, so they are glitch-free.
    assign level = level_q;
    assign pos   = level_q & ~level_d1;
    assign neg   = ~level_q & level_d1;
    assign evt   = (mode[0] & pos) | (mode[1] & neg);

`ifdef EDGE_DET_STICKY_EN
    logic flag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= 1'b0;
        end else if (evt) begin
            flag_q <= 1'b1;
        end else if (clr) begin
            flag_q <= 1'b0;
        end
    end

    assign flag = flag_q;
`else
    logic unused_clr;
    assign unused_clr = clr;
    assign flag       = 1'b0;
`endif

endmodule : edge_det_chan

// File: rtl/edge_detect_multi.sv
// ---------------------------------------------------------------------------
// edge_detect_multi
// Multi-channel synchronise / debounce / edge-detect block. Each channel is
// an independent edge_det_chan; simultaneous events on several channels all
// report in the same cycle.
//
// Configuration macro: EDGE_DET_STICKY_EN
//   defined   -> per-channel sticky flags in oFlag, oIrq = |oFlag
//   undefined -> iClr ignored, oFlag and oIrq tied to 0
//
// Parameters
//   CH        number of channels (1..32)
//   SYNC_STG  synchroniser flops per channel (0..4), 0 = already synchronous
//   DB_CYC    stable cycles before the level changes (0..65535), 0 == 1
//
// Ports
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   iData   in   [CH]    raw channel inputs
//   iMode   in   [2*CH]  per-channel mode: 00 off, 01 rise, 10 fall, 11 both
//   oLevel  out  [CH]    synchronised, debounced level
//   oPos    out  [CH]    one-cycle pulse on oLevel 0->1
//   oNeg    out  [CH]    one-cycle pulse on oLevel 1->0
//   oEdge   out  [CH]    oPos/oNeg masked by iMode
//   iClr    in   [CH]    sticky-flag clear
//   oFlag   out  [CH]    sticky event flags
//   oIrq    out          OR of oFlag
// ---------------------------------------------------------------------------
module edge_detect_multi
    import edge_det_pkg::*;
#(
    parameter int CH       = 4,
    parameter int SYNC_STG = 2,
    parameter int DB_CYC   = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH-1:0]   iData,
    input  logic [2*CH-1:0] iMode,
    output logic [CH-1:0]   oLevel,
    output logic [CH-1:0]   oPos,
    output logic [CH-1:0]   oNeg,
    output logic [CH-1:0]   oEdge,
    input  logic [CH-1:0]   iClr,
    output logic [CH-1:0]   oFlag,
    output logic            oIrq
);

    generate
        for (genvar i = 0; i < CH; i++) begin : g_ch
            edge_det_chan #(
                .SYNC_STG (SYNC_STG),
                .DB_CYC   (DB_CYC)
            ) u_chan (
                .clk   (clk),
                .rst_n (rst_n),
                .data  (iData[i]),
                .mode  (iMode[2*i +: 2]),
                .clr   (iClr[i]),
                .level (oLevel[i]),
                .pos   (oPos[i]),
                .neg   (oNeg[i]),
                .evt   (oEdge[i]),
                .flag  (oFlag[i])
            );
        end
    endgenerate

`ifdef EDGE_DET_STICKY_EN
    assign oIrq = |oFlag;
`else
    assign oIrq = 1'b0;
`endif

endmodule : edge_detect_multi

// File: tb/tb_edge_detect_multi.sv
// Scoreboard bench: stimulus pushes the expected pulse (cycle, pos, neg,
// edge, level) into a per-instance queue; a monitor per instance pops and
// compares whenever that instance shows any oPos/oNeg pulse.
//   A: SYNC_STG=2 DB_CYC=0 (latency 3)
//   B: SYNC_STG=2 DB_CYC=8 (latency 10)
//   C: SYNC_STG=0 DB_CYC=0 (latency 1)
module tb_edge_detect_multi;
    import edge_det_pkg::*;

    typedef struct {
        int         cyc;
        logic [3:0] pos;
        logic [3:0] neg;
        logic [3:0] edg;
        logic [3:0] lvl;
    } exp_t;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    logic       rst_a, rst_b, rst_c;
    logic [3:0] d_a, d_b, d_c;
    logic [7:0] m_a, m_b, m_c;
    logic [3:0] c_a, c_b, c_c;
    logic [3:0] lv_a, p_a, n_a, e_a, f_a;
    logic [3:0] lv_b, p_b, n_b, e_b, f_b;
    logic [3:0] lv_c, p_c, n_c, e_c, f_c;
    logic       i_a, i_b, i_c;

    edge_detect_multi #(.CH(4), .SYNC_STG(2), .DB_CYC(0)) u_dut_a (
        .clk(clk), .rst_n(rst_a), .iData(d_a), .iMode(m_a),
        .oLevel(lv_a), .oPos(p_a), .oNeg(n_a), .oEdge(e_a),
        .iClr(c_a), .oFlag(f_a), .oIrq(i_a)
    );

    edge_detect_multi #(.CH(4), .SYNC_STG(2), .DB_CYC(8)) u_dut_b (
        .clk(clk), .rst_n(rst_b), .iData(d_b), .iMode(m_b),
        .oLevel(lv_b), .oPos(p_b), .oNeg(n_b), .oEdge(e_b),
        .iClr(c_b), .oFlag(f_b), .oIrq(i_b)
    );

    edge_detect_multi #(.CH(4), .SYNC_STG(0), .DB_CYC(0)) u_dut_c (
        .clk(clk), .rst_n(rst_c), .iData(d_c), .iMode(m_c),
        .oLevel(lv_c), .oPos(p_c), .oNeg(n_c), .oEdge(e_c),
        .iClr(c_c), .oFlag(f_c), .oIrq(i_c)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge: drive new data and queue the pulse it should cause.
    task automatic apply(input int which, input logic [3:0] d, p, n, e, l);
        exp_t x;
        x.cyc = cyc + ((which == 0) ? 3 : (which == 1) ? 10 : 1);
        x.pos = p;
        x.neg = n;
        x.edg = e;
        x.lvl = l;
        case (which)
            0: begin d_a = d; if ((p | n) != 4'd0) q_a.push_back(x); end
            1: begin d_b = d; if ((p | n) != 4'd0) q_b.push_back(x); end
            default: begin d_c = d; if ((p | n) != 4'd0) q_c.push_back(x); end
        endcase
    endtask

    task automatic mon(input int which, input logic [3:0] p, n, e, l, f, input logic irq);
        exp_t  x;
        bit    have;
        string tag;
        have = 1'b0;
        tag  = (which == 0) ? "A" : (which == 1) ? "B" : "C";
        case (which)
            0: if (q_a.size() > 0) begin x = q_a.pop_front(); have = 1'b1; end
            1: if (q_b.size() > 0) begin x = q_b.pop_front(); have = 1'b1; end
            default: if (q_c.size() > 0) begin x = q_c.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            chk({"unexpected_pulse_", tag}, {24'd0, p, n}, 32'd0);
        end else begin
            chk({"pulse_cycle_", tag}, cyc, x.cyc);
            chk({"oPos_", tag}, {28'd0, p}, {28'd0, x.pos});
            chk({"oNeg_", tag}, {28'd0, n}, {28'd0, x.neg});
            chk({"oEdge_", tag}, {28'd0, e}, {28'd0, x.edg});
            chk({"oLevel_", tag}, {28'd0, l}, {28'd0, x.lvl});
`ifndef EDGE_DET_STICKY_EN
            chk({"flags_off_", tag}, {27'd0, irq, f}, 32'd0);
`endif
        end
    endtask

    always @(negedge clk) if (rst_a === 1'b1 && (p_a | n_a) != 4'd0) mon(0, p_a, n_a, e_a, lv_a, f_a, i_a);
    always @(negedge clk) if (rst_b === 1'b1 && (p_b | n_b) != 4'd0) mon(1, p_b, n_b, e_b, lv_b, f_b, i_b);
    always @(negedge clk) if (rst_c === 1'b1 && (p_c | n_c) != 4'd0) mon(2, p_c, n_c, e_c, lv_c, f_c, i_c);

    task automatic chk_reset_a(input string name);
        chk({name, "_level"}, {28'd0, lv_a}, 32'd0);
        chk({name, "_pulses"}, {20'd0, p_a, n_a, e_a}, 32'd0);
        chk({name, "_flags"}, {27'd0, i_a, f_a}, 32'd0);
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        d_a = 4'h0; d_b = 4'h0; d_c = 4'h0;
        m_a = 8'hFF; m_b = 8'hFF; m_c = 8'hFF;
        c_a = 4'h0; c_b = 4'h0; c_c = 4'h0;

        wait_n(3);
        chk_reset_a("reset_a");
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        wait_n(5);

        // A: single rise then fall on ch0
        apply(0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001);
        wait_n(6);
        chk("level_held_a", {28'd0, lv_a}, 32'h1);
        apply(0, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        wait_n(6);

        // A: per-channel mode mask, all channels together
        m_a = {EDGE_BOTH, EDGE_FALL, EDGE_RISE, EDGE_OFF};
        wait_n(1);
        apply(0, 4'hF, 4'hF, 4'h0, 4'b1010, 4'hF);
        wait_n(6);
        apply(0, 4'h0, 4'h0, 4'hF, 4'b1100, 4'h0);
        wait_n(6);

        // A: sticky flag on ch2, rise-only
        c_a = 4'hF;
        wait_n(1);
        c_a = 4'h0;
        m_a = {EDGE_OFF, EDGE_RISE, EDGE_OFF, EDGE_OFF};
        wait_n(1);
`ifdef EDGE_DET_STICKY_EN
        chk("flag_cleared", {27'd0, i_a, f_a}, 32'd0);
`endif
        apply(0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100);
        wait_n(4);
`ifdef EDGE_DET_STICKY_EN
        chk("flag_set", {27'd0, i_a, f_a}, {27'd0, 1'b1, 4'b0100});
`else
        chk("flag_tied_0", {27'd0, i_a, f_a}, 32'd0);
`endif
        apply(0, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
        wait_n(6);
`ifdef EDGE_DET_STICKY_EN
        chk("flag_kept_on_masked_fall", {28'd0, f_a}, 32'h4);
`endif
        apply(0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100);
        wait_n(3);
        c_a = 4'b0100;
        wait_n(1);
        c_a = 4'b0000;
`ifdef EDGE_DET_STICKY_EN
        chk("flag_set_wins", {28'd0, f_a}, 32'h4);
`else
        chk("flag_ignores_clr", {27'd0, i_a, f_a}, 32'd0);
`endif
        wait_n(1);
        c_a = 4'b0100;
        wait_n(1);
        c_a = 4'b0000;
        chk("flag_clr_alone", {27'd0, i_a, f_a}, 32'd0);
        apply(0, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
        wait_n(6);

        // A: input held high through reset -> one oPos per channel at boot
        m_a = 8'hFF;
        rst_a = 1'b0;
        d_a = 4'hF;
        wait_n(2);
        chk_reset_a("held_in_reset_a");
        rst_a = 1'b1;
        apply(0, 4'hF, 4'hF, 4'h0, 4'hF, 4'hF);
        wait_n(8);
        apply(0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0);
        wait_n(6);

        // B: 5-cycle glitch rejected, 8-cycle pulse accepted
        apply(1, 4'b0010, 4'h0, 4'h0, 4'h0, 4'h0);
        wait_n(5);
        apply(1, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0);
        wait_n(15);
        chk("glitch_no_level_b", {28'd0, lv_b}, 32'd0);
        apply(1, 4'b0010, 4'b0010, 4'h0, 4'b0010, 4'b0010);
        wait_n(8);
        apply(1, 4'b0000, 4'h0, 4'b0010, 4'b0010, 4'h0);
        wait_n(20);

        // B: reset asserted mid-debounce of a falling transition
        apply(1, 4'b0001, 4'b0001, 4'h0, 4'b0001, 4'b0001);
        wait_n(14);
        apply(1, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0);
        wait_n(4);
        #2 rst_b = 1'b0;
        #1;
        chk("async_reset_level_b", {28'd0, lv_b}, 32'd0);
        chk("async_reset_pulses_b", {20'd0, p_b, n_b, e_b}, 32'd0);
        @(negedge clk);
        wait_n(2);
        rst_b = 1'b1;
        wait_n(25);
        chk("no_pulse_after_reset_b", {28'd0, lv_b}, 32'd0);

        // C: no synchroniser, simultaneous rise on ch0 and fall on ch3
        apply(2, 4'b1000, 4'b1000, 4'h0, 4'b1000, 4'b1000);
        wait_n(3);
        apply(2, 4'b0001, 4'b0001, 4'b1000, 4'b1001, 4'b0001);
        wait_n(3);
        apply(2, 4'b0000, 4'h0, 4'b0001, 4'b0001, 4'h0);
        wait_n(3);

        chk("pending_a", q_a.size(), 32'd0);
        chk("pending_b", q_b.size(), 32'd0);
        chk("pending_c", q_c.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_edge_detect_multi

// File: doc/edge_detect_multi.md
Name: edge_detect_multi

Overview:
Parametrised multi-channel successor to the single-bit edge detector.
- Each channel takes an asynchronous or noisy 1-bit input and passes it through a configurable synchroniser and a stable-count debounce filter.
- Each channel emits rising/falling pulses plus a per-channel mode-masked event pulse.
- Sits between board-level inputs (keys, sensor strobes, external triggers) and the mid-level control FSMs, all in the 50 MHz domain.

Parameters:
- CH, 4, number of independent channels (1..32).
- SYNC_STG, 2, synchroniser flops per channel (0..4); 0 = input already synchronous, no synchroniser flops.
- DB_CYC, 0, stable cycles required before the filtered level changes (0..65535); 0 and 1 are equivalent (no filtering).

Ports:
- clk  input  1  system clock, 50 MHz, rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous to clk upstream.
- iData  input  CH  raw channel inputs.
- iMode  input  2*CH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both.
- oLevel  output  CH  synchronised, debounced level per channel.
- oPos  output  CH  1-cycle pulse on oLevel 0->1.
- oNeg  output  CH  1-cycle pulse on oLevel 1->0.
- oEdge  output  CH  oPos/oNeg masked by iMode.
- iClr  input  CH  sticky-flag clear (only with EDGE_DET_STICKY_EN).
- oFlag  output  CH  sticky event flags (only with EDGE_DET_STICKY_EN).
- oIrq  output  1  OR of oFlag (only with EDGE_DET_STICKY_EN).

Behaviour:
- Reset: all synchroniser flops, debounce counters, level, level_d1, oFlag = 0. oLevel, oPos, oNeg, oEdge, oIrq = 0 for the whole reset.
- Synchroniser: s[0]<=iData[i], s[k]<=s[k-1]. synced = s[SYNC_STG-1], or iData[i] when SYNC_STG=0.
- Debounce, counter width clog2(DB_CYC+1):
  - synced==level: cnt<=0.
  - synced!=level and cnt==max(DB_CYC,1)-1: level<=synced, cnt<=0.
  - Otherwise: cnt<=cnt+1.
- Glitch rejection: any excursion of synced shorter than max(DB_CYC,1) cycles resets cnt and never reaches level.
- Detect: level_d1<=level each cycle. oPos=level&~level_d1, oNeg=~level&level_d1. Both are combinational from flops only, so glitch-free.
- Latency: iData change set up before edge 1 -> level changes at edge SYNC_STG+max(DB_CYC,1). The pulse is high for exactly the following cycle.
- Pulse spacing: oPos and oNeg on the same channel never coincide. Minimum spacing between opposite pulses is max(DB_CYC,1) cycles.
- Mode: oEdge[i] = (mode[0]&oPos[i]) | (mode[1]&oNeg[i]). iMode is combinational and takes effect the same cycle. oPos/oNeg are never masked.
- Channel independence: channels are fully independent; simultaneous events on any set of channels all report in the same cycle.
- After reset release with an input held high: level rises after the normal latency and one oPos is produced. This is intended, so that "already pressed at boot" is visible.
- Reset asserted mid-debounce: the count is discarded; no pulse is produced by the aborted transition.
- Counter never wraps: it is bounded by the compare and reset to 0 whenever synced equals level.

Optional Feature:
- Macro EDGE_DET_STICKY_EN.
- Defined:
  - oFlag[i] sets on oEdge[i] and clears on iClr[i]; set wins when both occur in the same cycle.
  - oIrq = |oFlag (combinational from flops).
  - oFlag resets to 0.
- Undefined: iClr is ignored; oFlag is tied to 0 and oIrq to 0; no flag flops are synthesised.

Decomposition:
- Package edge_det_pkg:
  - mode constants EDGE_OFF=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11;
  - clog2 constant function for the counter width.
- Sub-module edge_det_chan: one channel (sync + debounce + level/level_d1 + pulses + mode mask + optional flag). The top is a generate loop over CH plus oIrq.

Test Plan:
- CH=4, SYNC_STG=2, DB_CYC=0: iData[0] 0->1 before edge 10 -> oLevel[0]=1 after edge 12, oPos[0]=1 only between edges 12 and 13, oNeg all 0.
- DB_CYC=8: iData[1] high for 5 cycles then low -> no oPos[1] or oLevel change. High for 8 cycles -> oPos[1] once, at edge SYNC_STG+8 after the first sample.
- iMode=8'b11_10_01_00 with all four inputs toggling 0->1->0: oEdge = {rise+fall, fall only, rise only, none}. oPos/oNeg pulse on all four channels.
- Hold iData=4'hF through reset; release rst_n -> each channel gives one oPos after the latency, no oNeg. Assert rst_n mid-debounce -> outputs 0 immediately, no pulse afterwards.
- EDGE_DET_STICKY_EN, mode 01 on ch2: rising edge -> oFlag[2]=1, oIrq=1. iClr[2] in the same cycle as a new oEdge[2] -> oFlag[2] stays 1. iClr[2] alone -> oFlag[2]=0, oIrq=0.
- SYNC_STG=0, DB_CYC=0: iData change -> pulse after 1 edge. Both simultaneous 0->1 on ch0 and 1->0 on ch3 -> oPos[0] and oNeg[3] in the same cycle.
